// File: rtl/manchester_mod.sv
// manchester_mod: Manchester (bi-phase) modulator with a registered line output.
// Define MANCHESTER_MOD_SYNC_IN_EN to add 2-flop synchronisers on in_enable and in_data.
module manchester_mod #(
    parameter int   HALF_BIT_CYCLES = 4,
    parameter logic IDLE_LEVEL      = 1'b0,
    parameter logic CONVENTION      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_enable,
    input  logic in_data,
    output logic out_data
);
    localparam int CW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(HALF_BIT_CYCLES - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          phase_q;
    logic          bit_q;
    logic          out_q;
    logic          en;
    logic          din;
`ifdef MANCHESTER_MOD_SYNC_IN_EN
    logic [1:0] en_sync_q;
    logic [1:0] din_sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync_q  <= '0;
            din_sync_q <= '0;
        end else begin
            en_sync_q  <= {en_sync_q[0], in_enable};
            din_sync_q <= {din_sync_q[0], in_data};
        end
    end
    assign en  = en_sync_q[1];
    assign din = din_sync_q[1];
`else
    assign en  = in_enable;
    assign din = in_data;
`endif
    // A bit boundary in RUN restarts exactly like leaving IDLE, giving gapless back-to-back bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= 1'b0;
            out_q   <= IDLE_LEVEL;
        end else if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            out_q   <= IDLE_LEVEL;
        end else if (state_q == IDLE || (cnt_q == TERM && phase_q)) begin
            state_q <= RUN;
            bit_q   <= din;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            out_q   <= ~din ^ CONVENTION;
        end else if (cnt_q == TERM) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
            out_q   <= bit_q ^ CONVENTION;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end
    assign out_data = out_q;
endmodule

// File: tb/tb_manchester_mod.sv
// tb_manchester_mod: directed checks of manchester_mod with HALF_BIT_CYCLES=4, IDLE_LEVEL=0, CONVENTION=0.
module tb_manchester_mod;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_enable = 1'b0;
    logic in_data = 1'b0;
    logic out_data;
    int   errors = 0;
    int   checks = 0;

    manchester_mod #(.HALF_BIT_CYCLES(4), .IDLE_LEVEL(1'b0), .CONVENTION(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_enable(in_enable), .in_data(in_data), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        in_enable = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = i[0];
            tick();
            checks++;
            if (out_data !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d out=%b exp=0", i, out_data);
            end
        end
        in_data = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_data !== 1'b1) begin
            errors++;
            $display("FAIL reset_release out=%b exp=1", out_data);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_data !== 1'b0) begin
            errors++;
            $display("FAIL reset_async out=%b exp=0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_enable = 1'b0;
        tick();
    endtask

    task automatic test_disabled();
        in_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_data = (i / 4) % 2 == 1;
            tick();
            checks++;
            if (out_data !== 1'b0) begin
                errors++;
                $display("FAIL disabled cyc=%0d out=%b exp=0", i, out_data);
            end
        end
    endtask

    task automatic test_enable_ones();
        logic [15:0] exp = 16'b0000_1111_0000_1111;
        go_idle();
        in_enable = 1'b1;
        in_data = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (out_data !== exp[15-i]) begin
                errors++;
                $display("FAIL enable_ones cyc=%0d out=%b exp=%b", i, out_data, exp[15-i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp = 32'b0000_1111_1111_0000_0000_1111_1111_0000;
        logic [3:0]  bits = 4'b1010;
        go_idle();
        in_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = bits[3 - i / 8];
            tick();
            checks++;
            if (out_data !== exp[31-i]) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d out=%b exp=%b", i, out_data, exp[31-i]);
            end
        end
    endtask

    task automatic test_mid_bit_data();
        logic [16:0] dat = 17'b1100_0000_0011_1111_1;
        logic [16:0] exp = 17'b0000_1111_1111_0000_0;
        go_idle();
        in_enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = dat[16-i];
            tick();
            checks++;
            if (out_data !== exp[16-i]) begin
                errors++;
                $display("FAIL mid_bit_data cyc=%0d out=%b exp=%b", i, out_data, exp[16-i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [13:0] en  = 14'b1110_0111_1111_11;
        logic [13:0] exp = 14'b1110_0111_1000_01;
        go_idle();
        in_data = 1'b0;
        in_enable = 1'b1;
        #2;
        checks++;
        if (out_data !== 1'b0) begin
            errors++;
            $display("FAIL abort_latency out=%b exp=0", out_data);
        end
        for (int i = 0; i < 14; i++) begin
            in_enable = en[13-i];
            tick();
            checks++;
            if (out_data !== exp[13-i]) begin
                errors++;
                $display("FAIL abort cyc=%0d out=%b exp=%b", i, out_data, exp[13-i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_enable_ones();
        test_back_to_back();
        test_mid_bit_data();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
